// File: rtl/pulse_train_gen.sv
// Turns single-cycle request strobes into fixed-width pulses separated by a minimum gap,
// queuing overlapping requests. Optional pulse counter: define PULSE_TRAIN_GEN_CNT_EN.
module pulse_train_gen #(
  parameter int HIGH_W = 4,
  parameter int LOW_W  = 2,
  parameter int PEND_W = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              trig_i,
  input  logic              clr_i,
  output logic              pulse_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              ovf_o,
`ifdef PULSE_TRAIN_GEN_CNT_EN
  output logic [15:0]       pulse_cnt_o,
`endif
  output logic [1:0]        state_o
);

  if (HIGH_W < 1 || HIGH_W > 255) begin : g_bad_high_w
    $fatal(1, "pulse_train_gen: HIGH_W must be in 1..255");
  end
  if (LOW_W < 1 || LOW_W > 255) begin : g_bad_low_w
    $fatal(1, "pulse_train_gen: LOW_W must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0]        HIGH_RELOAD = 8'(HIGH_W - 1);
  localparam logic [7:0]        LOW_RELOAD  = 8'(LOW_W - 1);
  localparam logic [PEND_W-1:0] PEND_MAX    = '1;

  state_t            state_q, state_n;
  logic [7:0]        phase_q, phase_n;
  logic [PEND_W-1:0] pend_q, pend_n;
  logic              ovf_q, ovf_n;
  logic              pulse_q, busy_q;
  logic              start, direct, from_q, enq, drop;

  // trig_i has no backpressure: every sampled-high cycle is a request that is either
  // started directly, queued, or dropped (and flagged) when the queue is full.
  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    start   = 1'b0;
    direct  = 1'b0;
    from_q  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_i) begin
          state_n = S_HIGH;
          phase_n = HIGH_RELOAD;
          start   = 1'b1;
          direct  = 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_q == 8'd0) begin
          state_n = S_GAP;
          phase_n = LOW_RELOAD;
        end else begin
          phase_n = phase_q - 8'd1;
        end
      end
      S_GAP: begin
        if (phase_q == 8'd0) begin
          // Queued requests take precedence; a same-cycle trig is then enqueued instead.
          if (pend_q != '0) begin
            state_n = S_HIGH;
            phase_n = HIGH_RELOAD;
            start   = 1'b1;
            from_q  = 1'b1;
          end else if (trig_i) begin
            state_n = S_HIGH;
            phase_n = HIGH_RELOAD;
            start   = 1'b1;
            direct  = 1'b1;
          end else begin
            state_n = S_IDLE;
            phase_n = 8'd0;
          end
        end else begin
          phase_n = phase_q - 8'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        phase_n = 8'd0;
      end
    endcase
  end

  always_comb begin
    enq    = trig_i && !direct;
    drop   = enq && !from_q && (pend_q == PEND_MAX);
    pend_n = pend_q;
    if (enq && !from_q && !drop) begin
      pend_n = pend_q + 1'b1;
    end else if (from_q && !enq) begin
      pend_n = pend_q - 1'b1;
    end
    if (drop) begin
      ovf_n = 1'b1;
    end else if (clr_i) begin
      ovf_n = 1'b0;
    end else begin
      ovf_n = ovf_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      phase_q <= 8'd0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      pend_q  <= pend_n;
      ovf_q   <= ovf_n;
      pulse_q <= (state_n == S_HIGH);
      busy_q  <= (state_n != S_IDLE) || (pend_n != '0);
    end
  end

`ifdef PULSE_TRAIN_GEN_CNT_EN
  logic [15:0] cnt_q;

  // A start in the same cycle as clr_i counts as the first pulse after the clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= 16'd0;
    end else if (clr_i) begin
      cnt_q <= start ? 16'd1 : 16'd0;
    end else if (start) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign pulse_cnt_o = cnt_q;
`endif

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign pend_o  = pend_q;
  assign ovf_o   = ovf_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: instance a uses defaults, instance b uses PEND_W=2.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rstn;
  logic       trig_a, clr_a, pulse_a, busy_a, ovf_a;
  logic [3:0] pend_a;
  logic [1:0] state_a;
  logic       trig_b, clr_b, pulse_b, busy_b, ovf_b;
  logic [1:0] pend_b;
  logic [1:0] state_b;
`ifdef PULSE_TRAIN_GEN_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pulse_train_gen #(.HIGH_W(4), .LOW_W(2), .PEND_W(4)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .trig_i(trig_a), .clr_i(clr_a),
    .pulse_o(pulse_a), .busy_o(busy_a), .pend_o(pend_a), .ovf_o(ovf_a),
`ifdef PULSE_TRAIN_GEN_CNT_EN
    .pulse_cnt_o(cnt_a),
`endif
    .state_o(state_a)
  );

  pulse_train_gen #(.HIGH_W(4), .LOW_W(2), .PEND_W(2)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .trig_i(trig_b), .clr_i(clr_b),
    .pulse_o(pulse_b), .busy_o(busy_b), .pend_o(pend_b), .ovf_o(ovf_b),
`ifdef PULSE_TRAIN_GEN_CNT_EN
    .pulse_cnt_o(cnt_b),
`endif
    .state_o(state_b)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; trig_a = 1'b0; clr_a = 1'b0; trig_b = 1'b0; clr_b = 1'b0;
    tick(); tick();
    n_checks++;
    if ({pulse_a, busy_a, pend_a, ovf_a} !== 7'd0) begin
      n_fail++; $display("FAIL reset_a: got %b expected 0", {pulse_a, busy_a, pend_a, ovf_a});
    end
    n_checks++;
    if ({pulse_b, busy_b, pend_b, ovf_b} !== 5'd0) begin
      n_fail++; $display("FAIL reset_b: got %b expected 0", {pulse_b, busy_b, pend_b, ovf_b});
    end
    @(negedge clk); rstn = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single();
    logic ep, eb;
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ep = (i < 4); eb = (i < 6);
      n_checks++;
      if (pulse_a !== ep) begin n_fail++; $display("FAIL single_pulse[%0d]: got %b expected %b", i, pulse_a, ep); end
      n_checks++;
      if (busy_a !== eb) begin n_fail++; $display("FAIL single_busy[%0d]: got %b expected %b", i, busy_a, eb); end
      n_checks++;
      if (pend_a !== 4'd0) begin n_fail++; $display("FAIL single_pend[%0d]: got %0d expected 0", i, pend_a); end
      tick();
    end
  endtask

  task automatic test_burst();
    logic ep, eb, prev;
    logic [3:0] epend, peak;
    int rises;
    rises = 0; prev = 1'b0; peak = 4'd0;
    trig_a = 1'b1; tick();
    for (int i = 0; i < 21; i++) begin
      trig_a = (i < 2);
      ep = (i < 18) && ((i % 6) < 4);
      eb = (i < 18);
      epend = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : (i < 6) ? 4'd2 : (i < 12) ? 4'd1 : 4'd0;
      n_checks++;
      if (pulse_a !== ep) begin n_fail++; $display("FAIL burst_pulse[%0d]: got %b expected %b", i, pulse_a, ep); end
      n_checks++;
      if (busy_a !== eb) begin n_fail++; $display("FAIL burst_busy[%0d]: got %b expected %b", i, busy_a, eb); end
      n_checks++;
      if (pend_a !== epend) begin n_fail++; $display("FAIL burst_pend[%0d]: got %0d expected %0d", i, pend_a, epend); end
      if (pulse_a === 1'b1 && prev === 1'b0) rises++;
      if (pend_a > peak) peak = pend_a;
      prev = pulse_a;
      tick();
    end
    trig_a = 1'b0;
    n_checks++;
    if (rises !== 3) begin n_fail++; $display("FAIL burst_edges: got %0d expected 3", rises); end
    n_checks++;
    if (peak !== 4'd2) begin n_fail++; $display("FAIL burst_peak: got %0d expected 2", peak); end
  endtask

  task automatic test_overflow();
    logic eo, prev;
    logic [1:0] epend;
    int rises;
    rises = 0; prev = 1'b0;
    trig_b = 1'b1; tick();
    for (int i = 0; i < 28; i++) begin
      trig_b = (i < 5);
      eo = (i >= 4);
      epend = (i < 3) ? 2'(i) : (i < 6) ? 2'd3 : (i < 12) ? 2'd2 : (i < 18) ? 2'd1 : 2'd0;
      n_checks++;
      if (ovf_b !== eo) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, ovf_b, eo); end
      n_checks++;
      if (pend_b !== epend) begin n_fail++; $display("FAIL ovf_pend[%0d]: got %0d expected %0d", i, pend_b, epend); end
      n_checks++;
      if (busy_b !== (i < 24)) begin n_fail++; $display("FAIL ovf_busy[%0d]: got %b expected %b", i, busy_b, (i < 24)); end
      if (pulse_b === 1'b1 && prev === 1'b0) rises++;
      prev = pulse_b;
      tick();
    end
    n_checks++;
    if (rises !== 4) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 4", rises); end
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    n_checks++;
    if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf_b); end
  endtask

  task automatic test_clr_vs_drop();
    trig_b = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (pend_b !== 2'd3) begin n_fail++; $display("FAIL cvd_full: got %0d expected 3", pend_b); end
    n_checks++;
    if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL cvd_pre_ovf: got %b expected 0", ovf_b); end
    clr_b = 1'b1; tick();
    n_checks++;
    if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL cvd_drop_wins: got %b expected 1", ovf_b); end
    n_checks++;
    if (pend_b !== 2'd3) begin n_fail++; $display("FAIL cvd_pend_hold: got %0d expected 3", pend_b); end
    trig_b = 1'b0; tick(); clr_b = 1'b0;
    n_checks++;
    if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL cvd_clr_alone: got %b expected 0", ovf_b); end
    for (int i = 0; i < 30; i++) tick();
    n_checks++;
    if ({busy_b, pend_b} !== 3'd0) begin n_fail++; $display("FAIL cvd_drain: got %b expected 0", {busy_b, pend_b}); end
  endtask

  task automatic test_reset_mid();
    trig_b = 1'b1; tick();
    trig_a = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    trig_a = 1'b0; trig_b = 1'b0;
    n_checks++;
    if ({pulse_a, pend_a} !== 5'b1_0011) begin n_fail++; $display("FAIL mid_pre_a: got %b expected 10011", {pulse_a, pend_a}); end
    n_checks++;
    if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovf: got %b expected 1", ovf_b); end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({pulse_a, busy_a, pend_a, ovf_a} !== 7'd0) begin n_fail++; $display("FAIL mid_rst_a: got %b expected 0", {pulse_a, busy_a, pend_a, ovf_a}); end
    n_checks++;
    if ({pulse_b, busy_b, pend_b, ovf_b} !== 5'd0) begin n_fail++; $display("FAIL mid_rst_b: got %b expected 0", {pulse_b, busy_b, pend_b, ovf_b}); end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({pulse_a, busy_a, pulse_b, busy_b} !== 4'd0) begin
        n_fail++; $display("FAIL mid_quiet[%0d]: got %b expected 0", i, {pulse_a, busy_a, pulse_b, busy_b});
      end
    end
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    n_checks++;
    if (pulse_a !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got %b expected 1", pulse_a); end
    for (int i = 0; i < 10; i++) tick();
  endtask

`ifdef PULSE_TRAIN_GEN_CNT_EN
  task automatic test_pulse_cnt();
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    n_checks++;
    if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d expected 0", cnt_a); end
    trig_a = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    trig_a = 1'b0;
    for (int i = 0; i < 24; i++) tick();
    n_checks++;
    if (cnt_a !== 16'd3) begin n_fail++; $display("FAIL cnt_burst: got %0d expected 3", cnt_a); end
    clr_a = 1'b1; trig_a = 1'b1; tick(); clr_a = 1'b0; trig_a = 1'b0;
    n_checks++;
    if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL cnt_clr_start: got %0d expected 1", cnt_a); end
    for (int i = 0; i < 10; i++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_clr_vs_drop();
    test_reset_mid();
`ifdef PULSE_TRAIN_GEN_CNT_EN
    test_pulse_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
